receptor: RTL and testbench

- RS232 8N1 serial receiver.
- Pairs with the existing serial transmitter on the opposite link end.
- Oversamples asynchronous RxD using a clk-domain enable pulse, recovers bytes LSB-first and presents each with a one-cycle valid strobe.
- Accepts frames with 1 or more stop bits; the transmitter's 2nd stop bit is seen as idle.
- Sits between the board RxD pin and the processor's I/O register block.

---
 rtl/rs232_pkg.sv | 20 ++
 rtl/rx_sync.sv | 25 ++
 rtl/receptor.sv | 136 +++++++++++++
 tb/tb_receptor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: receiver state encoding, frame constants and a
// majority-vote helper.
package rs232_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for asynchronous inputs. It resets to 1, which is the
// idle level of a serial line.
module rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/receptor.sv
// RS232 8N1 receiver with baudTick oversampling, LSB-first byte recovery and a
// one-cycle dataReady strobe. Optional RX_MAJORITY_EN enables 2-of-3 voting.
module receptor
  import rs232_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  input  logic                 baudTick,
  output logic [DATA_BITS-1:0] data,
  output logic                 dataReady,
  output logic                 busy,
  output logic                 frameError
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_EN
  // The vote needs the tick after mid-bit. Delaying the start decision by one
  // tick shifts every later decision by one tick as well.
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(OVERSAMPLE / 2);
`else
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ready;
  logic                 r_ferr;
  logic                 w_rxS;
  logic                 w_sample;

  rx_sync u_rx_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (RxD),
    .o_sync  (w_rxS)
  );

`ifdef RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst)
      r_hist <= '1;
    else if (baudTick)
      r_hist <= {r_hist[0], w_rxS};
  end

  assign w_sample = maj3(r_hist[1], r_hist[0], w_rxS);
`else
  assign w_sample = w_rxS;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (baudTick) begin
        case (r_state)
          IDLE: begin
            if (!w_rxS) begin
              r_state <= START;
              r_cnt   <= '0;
            end
          end
          START: begin
            if (r_cnt == START_CNT) begin
              if (w_sample) begin
                r_state <= IDLE;
              end else begin
                r_state <= DATA;
                r_cnt   <= '0;
                r_idx   <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DATA: begin
            if (r_cnt == LAST_CNT) begin
              r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
              r_cnt   <= '0;
              r_idx   <= r_idx + 1'b1;
              if (r_idx == LAST_IDX)
                r_state <= STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STOP: begin
            if (r_cnt == LAST_CNT) begin
              r_cnt <= '0;
              if (w_sample) begin
                r_data  <= r_shift;
                r_ready <= 1'b1;
                r_ferr  <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= BREAK;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          BREAK: begin
            if (w_rxS)
              r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data       = r_data;
  assign dataReady  = r_ready;
  assign frameError = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_receptor.sv
// Self-checking bench for receptor: vector table of frames plus hand-written
// glitch, break, mid-frame reset and mid-bit glitch sequences.
module tb_receptor;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       baudTick;
  logic [7:0] data;
  logic       dataReady;
  logic       busy;
  logic       frameError;

  receptor #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .RxD        (RxD),
    .baudTick   (baudTick),
    .data       (data),
    .dataReady  (dataReady),
    .busy       (busy),
    .frameError (frameError)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pulse = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       prev_ready = 1'b0;

  typedef struct {
    logic [7:0]  tx;
    int unsigned nstop;
    int unsigned gap;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    baudTick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      baudTick = 1'b1;
      @(negedge clk);
      baudTick = 1'b0;
    end
  end

  // Returns 1 ns after the n-th baudTick edge, so RxD changes away from the edge.
  task automatic wait_ticks(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      while (!baudTick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned nstop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    repeat (nstop) send_bit(stop);
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (dataReady) begin
      n_pulse++;
      check("pulse_width", {31'd0, prev_ready}, 32'd0);
      check("busy_at_ready", {31'd0, busy}, 32'd0);
      check("ferr_at_ready", {31'd0, frameError}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got data 0x%0h expected no pulse", data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", {24'd0, data}, {24'd0, e});
        last_data = e;
      end
    end
    prev_ready = dataReady;
  end

  initial begin : main
    int         p0;
    logic [7:0] d0;
    logic       e0;
    logic [7:0] b5a;
    logic [7:0] b81;

    vecs[0] = '{8'hA5, 1, 0, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 2, 0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 2, 0, 8'hFF, 1'b0};
    vecs[3] = '{8'h55, 1, 0, 8'h55, 1'b0};
    vecs[4] = '{8'h80, 1, 8, 8'h80, 1'b0};
    vecs[5] = '{8'h01, 1, 3, 8'h01, 1'b0};

    rst = 1'b1;
    RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_ready", {31'd0, dataReady}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, frameError}, 32'd0);
    wait_ticks(20);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].tx, 1'b1, vecs[i].nstop);
      wait_ticks(vecs[i].gap);
      check($sformatf("vec%0d_ferr", i), {31'd0, frameError}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_drained", i), exp_q.size(), 32'd0);
    end
    check("vec_pulses", n_pulse, 32'd6);

    p0 = n_pulse;
    d0 = data;
    e0 = frameError;
    RxD = 1'b0;
    wait_ticks(4);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    RxD = 1'b1;
    wait_ticks(12);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_no_pulse", n_pulse, p0);
    check("glitch_data", {24'd0, data}, {24'd0, d0});
    check("glitch_ferr", {31'd0, frameError}, {31'd0, e0});

    send_frame(8'h3C, 1'b0, 1);
    check("brk_ferr", {31'd0, frameError}, 32'd1);
    check("brk_busy", {31'd0, busy}, 32'd1);
    check("brk_data", {24'd0, data}, {24'd0, last_data});
    wait_ticks(3 * OS);
    check("brk_hold", {31'd0, busy}, 32'd1);
    check("brk_no_pulse", n_pulse, p0);
    RxD = 1'b1;
    wait_ticks(4);
    check("brk_exit", {31'd0, busy}, 32'd0);
    wait_ticks(OS);
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 1);
    check("after_brk_ferr", {31'd0, frameError}, 32'd0);
    check("after_brk_drained", exp_q.size(), 32'd0);

    b5a = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b5a[i]);
    RxD = b5a[4];
    wait_ticks(4);
    p0 = n_pulse;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    last_data = 8'h00;
    check("mrst_data", {24'd0, data}, 32'd0);
    check("mrst_ready", {31'd0, dataReady}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ferr", {31'd0, frameError}, 32'd0);
    RxD = 1'b1;
    wait_ticks(2 * OS);
    check("mrst_no_pulse", n_pulse, p0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1);
    check("mrst_drained", exp_q.size(), 32'd0);
    wait_ticks(OS);

`ifdef RX_MAJORITY_EN
    exp_q.push_back(8'h81);
`else
    exp_q.push_back(8'h89);
`endif
    b81 = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b81[i]);
    RxD = b81[3];
    wait_ticks(8);
    RxD = ~b81[3];
    wait_ticks(1);
    RxD = b81[3];
    wait_ticks(7);
    for (int i = 4; i < 8; i++) send_bit(b81[i]);
    send_bit(1'b1);
    wait_ticks(OS);

    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_ferr", {31'd0, frameError}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
